keypad_scanner: RTL and testbench

- Drives the column lines of the 4x4 Pmod keypad and reads the row lines back.
- Resolves each full scan to a single key, then debounces it across consecutive scans.
- Delivers one press event per key press as a 4-bit hex code over a valid/ack handshake to the menu FSM.
- Replaces the free-running per-line debouncers with a true scanned matrix interface.

---
 rtl/keypad_scanner.sv | 232 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 4x4 Pmod keypad matrix, debounces whole-scan results
// and hands press events to the consumer over valid/ack. Macro KYPD_REPEAT_EN adds auto-repeat.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned REPEAT_SCANS   = 250
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] kypd_col,
   input  logic [3:0] kypd_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);
   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned STB_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

   localparam logic [1:0] DRIVE0 = 2'd0;
   localparam logic [1:0] DRIVE3 = 2'd3;

   localparam logic [1:0] RES_NONE   = 2'd0;
   localparam logic [1:0] RES_SINGLE = 2'd1;
   localparam logic [1:0] RES_MULTI  = 2'd2;

   logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       col_q, col_d;
   logic [15:0]      pressed_q, pressed_d;
   logic [1:0]       res_kind_q, res_kind_d;
   logic [3:0]       res_code_q, res_code_d;
   logic [STB_W-1:0] stable_q, stable_d;
   logic             held_q, held_d;
   logic [3:0]       held_code_q, held_code_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   logic [15:0]      scan_vec_c;
   logic [1:0]       n_set_c;
   logic [3:0]       hit_idx_c;
   logic [1:0]       res_kind_c;
   logic [3:0]       res_code_c;
   logic             scan_end_c, same_c, reached_c, evt_c;
   logic [3:0]       evt_code_c;

   // Pressed vector bit index is {column, row}.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;
         4'b11_01: code = 4'hF;
         4'b11_10: code = 4'hE;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

`ifdef KYPD_REPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
   logic [REP_W-1:0] rep_q, rep_d;
`else
   // Auto-repeat not built; parameter kept so both builds share one interface.
   if (REPEAT_SCANS == 0) begin : g_repeat_unused
   end
`endif

   // Current scan including this column's rows, and its classification.
   always_comb begin
      scan_vec_c = pressed_q;
      for (int r = 0; r < 4; r++) begin
         scan_vec_c[{state_q, 2'(r)}] = ~row_s2_q[r];
      end
      n_set_c   = 2'd0;
      hit_idx_c = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (scan_vec_c[i]) begin
            if (n_set_c != 2'd2) n_set_c = n_set_c + 2'd1;
            hit_idx_c = 4'(i);
         end
      end
      res_kind_c = (n_set_c == 2'd0) ? RES_NONE : (n_set_c == 2'd1) ? RES_SINGLE : RES_MULTI;
      res_code_c = (n_set_c == 2'd1) ? key_map(hit_idx_c[1:0], hit_idx_c[3:2]) : 4'd0;
   end

   always_comb begin
      row_s1_d    = kypd_row;
      row_s2_d    = row_s1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      pressed_d   = pressed_q;
      res_kind_d  = res_kind_q;
      res_code_d  = res_code_q;
      stable_d    = stable_q;
      held_d      = held_q;
      held_code_d = held_code_q;
      code_d      = code_q;
      valid_d     = valid_q;
      overrun_d   = overrun_q;
      same_c      = 1'b0;
      reached_c   = 1'b0;
      evt_c       = 1'b0;
      evt_code_c  = res_code_c;
`ifdef KYPD_REPEAT_EN
      rep_d       = rep_q;
`endif
      scan_end_c  = (cnt_q == CNT_LAST) && (state_q == DRIVE3);

      if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         state_d   = state_q + 2'd1;
         pressed_d = scan_vec_c;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (scan_end_c) begin
         pressed_d  = '0;
         res_kind_d = res_kind_c;
         res_code_d = res_code_c;
         same_c     = (res_kind_c == res_kind_q) && (res_code_c == res_code_q);
         if (!same_c) stable_d = STB_W'(1);
         else if (stable_q != STB_MAX) stable_d = stable_q + STB_W'(1);
         // Act only on the scan that first reaches the threshold.
         reached_c = (stable_d == STB_MAX) && !(same_c && (stable_q == STB_MAX));
         if (reached_c) begin
            case (res_kind_c)
               RES_SINGLE: begin
                  if (!held_q || (res_code_c != held_code_q)) evt_c = 1'b1;
                  held_d      = 1'b1;
                  held_code_d = res_code_c;
               end
               RES_NONE: held_d = 1'b0;
               default: ;
            endcase
         end
`ifdef KYPD_REPEAT_EN
         if (evt_c) begin
            rep_d = '0;
         end else if (held_q && (res_kind_c == RES_SINGLE) && (res_code_c == held_code_q)) begin
            if (rep_q == REP_LAST) begin
               rep_d      = '0;
               evt_c      = 1'b1;
               evt_code_c = held_code_q;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
         end else begin
            rep_d = '0;
         end
`endif
      end

      // A simultaneous ack frees the slot for the new event.
      if (evt_c) begin
         if (!valid_q || key_ack) begin
            code_d  = evt_code_c;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && key_ack) begin
         valid_d = 1'b0;
      end

      col_d = ~(4'b0001 << state_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         state_q     <= DRIVE0;
         cnt_q       <= '0;
         col_q       <= 4'b1110;
         pressed_q   <= '0;
         res_kind_q  <= RES_NONE;
         res_code_q  <= 4'd0;
         stable_q    <= '0;
         held_q      <= 1'b0;
         held_code_q <= 4'd0;
         code_q      <= 4'd0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef KYPD_REPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         row_s1_q    <= row_s1_d;
         row_s2_q    <= row_s2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         pressed_q   <= pressed_d;
         res_kind_q  <= res_kind_d;
         res_code_q  <= res_code_d;
         stable_q    <= stable_d;
         held_q      <= held_d;
         held_code_q <= held_code_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
`ifdef KYPD_REPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   assign kypd_col  = col_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;
   assign overrun   = overrun_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix stand-in plus a scan-level reference model of
// debounce and the valid/ack handshake; table vectors, directed corners, random keys.
module tb_keypad_scanner;
   localparam int SD   = 8;
   localparam int DS   = 2;
   localparam int RS   = 3;
   localparam int SCAN = 4 * SD;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] kypd_col, kypd_row, key_code;
   logic       key_valid, key_ack, key_held, overrun;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_SCANS(RS)) dut (
      .clk(clk), .rst(rst), .kypd_col(kypd_col), .kypd_row(kypd_row),
      .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
      .key_held(key_held), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Pressed keys, bit r*4+c; a pressed key pulls its row low while its column is driven.
   logic [15:0] keys;
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         kypd_row[r] = 1'b1;
         for (int c = 0; c < 4; c++)
            if (!kypd_col[c] && keys[r*4+c]) kypd_row[r] = 1'b0;
      end
   end

   logic [3:0] key_map [16];

   int checks = 0, passed = 0, tcount = 0;
   int m_n, m_prev, m_stable, m_rep, m_vcnt, m_hcode;
   logic m_valid, m_over, m_held;
   logic [3:0] m_code;
   bit   auto_ack = 0;
   int   ack_dly = 0;
   int   xfers = 0;
   logic [3:0] last_code;
   int   bad_codes = 0;
   logic [3:0] want_code;
   bit   lat_arm = 0;
   int   lat_t = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcount);
   endtask

   // Reference model, evaluated once per clock edge at the granularity of whole scans.
   task automatic model_edge();
      bit ev, reached, held_b;
      logic [3:0] ec;
      int res, nset, code, hcode_b;
      ev = 0; ec = 4'd0;
      if (rst) begin
         m_n = 0; m_prev = -1; m_stable = 0; m_rep = 0; m_vcnt = 0; m_hcode = 0;
         m_valid = 0; m_over = 0; m_held = 0; m_code = 4'd0;
         return;
      end
      m_n++;
      if (m_n % SCAN == 0) begin
         nset = 0; code = 0;
         for (int i = 0; i < 16; i++) if (keys[i]) begin nset++; code = int'(key_map[i]); end
         res = (nset == 0) ? -1 : (nset == 1) ? code : -2;
         if (res == m_prev) begin
            reached = (m_stable == DS - 1);
            if (m_stable < DS) m_stable++;
         end else begin
            m_stable = 1;
            reached = (DS == 1);
         end
         m_prev = res;
         held_b = m_held; hcode_b = m_hcode;
         if (reached && res >= 0) begin
            if (!m_held || res != m_hcode) begin ev = 1; ec = 4'(res); end
            m_held = 1; m_hcode = res;
         end else if (reached && res == -1) begin
            m_held = 0;
         end
`ifdef KYPD_REPEAT_EN
         if (ev) m_rep = 0;
         else if (held_b && res >= 0 && res == hcode_b) begin
            m_rep++;
            if (m_rep == RS) begin ev = 1; ec = 4'(hcode_b); m_rep = 0; end
         end else m_rep = 0;
`endif
      end
      if (ev && (!m_valid || key_ack)) begin
         m_code = ec; m_valid = 1; m_vcnt = 0;
      end else begin
         if (ev) m_over = 1;
         if (m_valid && key_ack) begin m_valid = 0; m_vcnt = 0; end
         else if (m_valid) m_vcnt++;
      end
   endtask

   task automatic step();
      logic [3:0] m_col;
      key_ack = auto_ack && m_valid && (m_vcnt >= ack_dly);
      if (key_valid && key_ack && !rst) begin
         xfers++; last_code = key_code;
         if (key_code != want_code) bad_codes++;
      end
      @(posedge clk);
      tcount++;
      model_edge();
      #1;
      m_col = ~(4'b0001 << ((m_n / SD) % 4));
      chk("kypd_col", int'(kypd_col), int'(m_col));
      chk("key_valid", int'(key_valid), int'(m_valid));
      chk("key_held", int'(key_held), int'(m_held));
      chk("overrun", int'(overrun), int'(m_over));
      if (m_valid) chk("key_code", int'(key_code), int'(m_code));
      if (lat_arm && key_valid) begin lat_t = tcount; lat_arm = 0; end
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); step(); rst = 1'b0;
   endtask

   // Keys change only right after a scan-evaluation edge, so every scan sees one key set.
   task automatic run_scans(input logic [15:0] k, input int nscan);
      keys = k;
      repeat (nscan * SCAN) step();
   endtask

   typedef struct { int row; int col; logic [3:0] code; } key_vec_t;
   key_vec_t vecs [16];

   initial begin
      int press_t;
      key_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                  4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
      vecs = '{'{0,0,4'h1}, '{0,1,4'h2}, '{0,2,4'h3}, '{0,3,4'hA},
               '{1,0,4'h4}, '{1,1,4'h5}, '{1,2,4'h6}, '{1,3,4'hB},
               '{2,0,4'h7}, '{2,1,4'h8}, '{2,2,4'h9}, '{2,3,4'hC},
               '{3,0,4'h0}, '{3,1,4'hF}, '{3,2,4'hE}, '{3,3,4'hD}};
      rst = 1'b1; keys = 16'h0; key_ack = 1'b0; last_code = 4'd0; want_code = 4'd0;
      m_valid = 0; m_vcnt = 0;

      // Reset state and idle scanning.
      do_reset();
      chk("rst_col", int'(kypd_col), 4'b1110);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_code", int'(key_code), 0);
      chk("rst_held", int'(key_held), 0);
      chk("rst_overrun", int'(overrun), 0);
      run_scans(16'h0, 7);

      // Every key through the map.
      auto_ack = 1; ack_dly = 3;
      for (int i = 0; i < 16; i++) begin
         xfers = 0; want_code = vecs[i].code;
         run_scans(16'(1) << (vecs[i].row * 4 + vecs[i].col), 3);
         run_scans(16'h0, 3);
         chk("tbl_code", int'(last_code), int'(vecs[i].code));
         chk("tbl_events", xfers, 1);
      end

      // Key 5: latency, single event, held until two NONE scans.
      xfers = 0; want_code = 4'h5; press_t = tcount; lat_arm = 1; lat_t = tcount + 1000;
      run_scans(16'(1) << 5, 4);
      chk("k5_latency_ok", int'((lat_t - press_t) <= 100), 1);
      chk("k5_held", int'(key_held), 1);
      run_scans(16'h0, 1);
      chk("k5_held_after1", int'(key_held), 1);
      run_scans(16'h0, 1);
      chk("k5_held_after2", int'(key_held), 0);
      chk("k5_events", xfers, 1);
      chk("k5_code", int'(last_code), 5);

      // Key 0 bouncing on alternate scans, then stable.
      xfers = 0; want_code = 4'h0;
      for (int s = 0; s < 6; s++) run_scans((s % 2 == 0) ? (16'(1) << 12) : 16'h0, 1);
      run_scans(16'h0, 1);
      chk("bounce_events", xfers, 0);
      run_scans(16'(1) << 12, 3);
      run_scans(16'h0, 2);
      chk("bounce_events_after", xfers, 1);
      chk("bounce_code", int'(last_code), 0);

      // Keys 1 and 9 together, then 9 released.
      xfers = 0; want_code = 4'h1;
      run_scans(16'h0401, 5);
      chk("multi_events", xfers, 0);
      chk("multi_held", int'(key_held), 0);
      run_scans(16'h0001, 3);
      run_scans(16'h0, 2);
      chk("multi_rel_events", xfers, 1);
      chk("multi_rel_code", int'(last_code), 1);

      // Event arriving in the same cycle as the ack of the previous one.
      auto_ack = 1; ack_dly = 63;
      run_scans(16'(1) << 6, 2);
      run_scans(16'(1) << 8, 2);
      chk("simul_valid", int'(key_valid), 1);
      chk("simul_code", int'(key_code), 7);
      chk("simul_overrun", int'(overrun), 0);
      ack_dly = 0;
      run_scans(16'h0, 3);

      // D never acked, then 3: dropped, overrun sticky until reset.
      auto_ack = 0;
      run_scans(16'(1) << 15, 3);
      run_scans(16'h0, 3);
      run_scans(16'(1) << 2, 3);
      chk("ovr_code", int'(key_code), 13);
      chk("ovr_valid", int'(key_valid), 1);
      chk("ovr_flag", int'(overrun), 1);
      auto_ack = 1; ack_dly = 0;
      run_scans(16'h0, 3);
      chk("ovr_ack_valid", int'(key_valid), 0);
      chk("ovr_sticky", int'(overrun), 1);
      do_reset();
      chk("ovr_cleared", int'(overrun), 0);

      // Reset while an event is pending discards it.
      auto_ack = 0;
      run_scans(16'(1) << 9, 3);
      chk("abort_valid_before", int'(key_valid), 1);
      keys = 16'h0;
      do_reset();
      chk("abort_valid", int'(key_valid), 0);
      chk("abort_code", int'(key_code), 0);
      chk("abort_held", int'(key_held), 0);

      // Holding A for 12 scans with prompt acks.
      auto_ack = 1; ack_dly = 1; xfers = 0; bad_codes = 0; want_code = 4'hA;
      run_scans(16'(1) << 3, 12);
      run_scans(16'h0, 2);
`ifdef KYPD_REPEAT_EN
      chk("hold_a_events", xfers, 4);
`else
      chk("hold_a_events", xfers, 1);
`endif
      chk("hold_a_codes", bad_codes, 0);

      // Random key sets checked against the model.
      for (int s = 0; s < 40; s++) begin
         int sel;
         logic [15:0] k;
         sel = int'($urandom_range(0, 9));
         k = 16'h0;
         if (sel >= 4 && sel < 8) k = 16'(1) << $urandom_range(0, 15);
         else if (sel >= 8) k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
         auto_ack = ($urandom_range(0, 5) != 0);
         ack_dly = int'($urandom_range(0, 40));
         want_code = key_code;
         run_scans(k, int'($urandom_range(1, 3)));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
